// File: rtl/mac_rs_fault_if.sv
// XGMII receive and transmit buses around the RS link-fault block.
// slave is the block's view; master is the MAC/PCS side driving it.
interface mac_rs_fault_if #(
  parameter int N_CHANNELS = 8
);
  logic [N_CHANNELS-1:0]   i_rx_xgmii_ctrl;
  logic [N_CHANNELS*8-1:0] i_rx_xgmii_data;
  logic [N_CHANNELS-1:0]   o_rx_xgmii_ctrl;
  logic [N_CHANNELS*8-1:0] o_rx_xgmii_data;
  logic [N_CHANNELS-1:0]   i_tx_xgmii_ctrl;
  logic [N_CHANNELS*8-1:0] i_tx_xgmii_data;
  logic [N_CHANNELS-1:0]   o_tx_xgmii_ctrl;
  logic [N_CHANNELS*8-1:0] o_tx_xgmii_data;

  modport slave (
    input  i_rx_xgmii_ctrl, i_rx_xgmii_data,
    input  i_tx_xgmii_ctrl, i_tx_xgmii_data,
    output o_rx_xgmii_ctrl, o_rx_xgmii_data,
    output o_tx_xgmii_ctrl, o_tx_xgmii_data
  );

  modport master (
    output i_rx_xgmii_ctrl, i_rx_xgmii_data,
    output i_tx_xgmii_ctrl, i_tx_xgmii_data,
    input  o_rx_xgmii_ctrl, o_rx_xgmii_data,
    input  o_tx_xgmii_ctrl, o_tx_xgmii_data
  );
endinterface

// File: rtl/mac_rs_fault.sv
// RS link-fault block: clause-46 fault detection on RX and
// frame-safe TX override (remote-fault sets or idles).
module mac_rs_fault #(
  parameter int N_CHANNELS    = 8,
  parameter int FAULT_SEQ_CNT = 4,
  parameter int COL_WINDOW    = 128,
  parameter int W_CNT         = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clk_en,
  input  logic             i_cfg_fault_en,
  mac_rs_fault_if.slave    xg,
  output logic [1:0]       o_link_fault,
  output logic             o_link_up,
  output logic [W_CNT-1:0] o_suppressed_cnt
);
  localparam int W_BYTE = 8;
  localparam int N_COL  = N_CHANNELS / 4;
  localparam int W_DATA = N_CHANNELS * W_BYTE;
  localparam int W_SEQ  = $clog2(FAULT_SEQ_CNT + 1);
  localparam int W_COL  = $clog2(COL_WINDOW + 2);

  localparam logic [W_SEQ-1:0] SEQ_MAX = W_SEQ'(FAULT_SEQ_CNT);
  localparam logic [W_COL-1:0] COL_MAX = W_COL'(COL_WINDOW + 1);

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [7:0] C_IDLE  = 8'h07;
  localparam logic [7:0] C_START = 8'hfb;
  localparam logic [7:0] C_TERM  = 8'hfd;
  localparam logic [7:0] C_SEQ   = 8'h9c;

  localparam logic [1:0]  T_LOCAL  = 2'b01;
  localparam logic [31:0] IDLE_COL = {4{C_IDLE}};
  localparam logic [31:0] RF_COL   = {8'h02, 8'h00, 8'h00, C_SEQ};

  logic [1:0]            st_q, st_d;
  logic [W_SEQ-1:0]      seq_q, seq_d;
  logic [1:0]            type_q, type_d;
  logic [W_COL-1:0]      col_q, col_d;
  logic [1:0]            fault_q, fault_d;
  logic                  frame_q, frame_d;
  logic                  mode_q, mode_d;
  logic [W_CNT-1:0]      cnt_q, cnt_d;
  logic [N_CHANNELS-1:0] rx_ctrl_q, rx_ctrl_d;
  logic [W_DATA-1:0]     rx_data_q, rx_data_d;
  logic [N_CHANNELS-1:0] tx_ctrl_q, tx_ctrl_d;
  logic [W_DATA-1:0]     tx_data_q, tx_data_d;

  logic                  ovr_on;
  logic [1:0]            seq_t;
  logic                  has_start;
  logic [3:0]            cc;
  logic [31:0]           cd;

  // Returns the fault type of a column, or 0 if it is not a fault set.
  function automatic logic [1:0] seq_type(
    input logic [3:0]  c,
    input logic [31:0] d
  );
    logic [1:0] t;
    t = 2'b00;
    if (c == 4'b0001 && d[23:0] == {16'h0000, C_SEQ} &&
        (d[31:24] == 8'h01 || d[31:24] == 8'h02))
      t = d[25:24];
    return t;
  endfunction

  always_comb begin
    st_d      = st_q;
    seq_d     = seq_q;
    type_d    = type_q;
    col_d     = col_q;
    fault_d   = fault_q;
    frame_d   = frame_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    rx_ctrl_d = xg.i_rx_xgmii_ctrl;
    rx_data_d = xg.i_rx_xgmii_data;
    tx_ctrl_d = xg.i_tx_xgmii_ctrl;
    tx_data_d = xg.i_tx_xgmii_data;
    seq_t     = 2'b00;
    has_start = 1'b0;
    cc        = '0;
    cd        = '0;
    ovr_on    = i_cfg_fault_en && (fault_q != 2'b00);
    for (int c = 0; c < N_COL; c++) begin
      cc    = xg.i_rx_xgmii_ctrl[4*c +: 4];
      cd    = xg.i_rx_xgmii_data[32*c +: 32];
      seq_t = seq_type(cc, cd);
      if (col_d != COL_MAX)
        col_d = col_d + W_COL'(1);
      if (seq_t != 2'b00) begin
        rx_ctrl_d[4*c +: 4]   = 4'hf;
        rx_data_d[32*c +: 32] = IDLE_COL;
        col_d = '0;
        if (!(st_d == ST_FAULT && seq_t == type_d)) begin
          if (st_d == ST_COUNT && seq_t == type_d)
            seq_d = seq_d + W_SEQ'(1);
          else
            seq_d = W_SEQ'(1);
          type_d = seq_t;
          st_d   = ST_COUNT;
          if (seq_d >= SEQ_MAX) begin
            st_d    = ST_FAULT;
            fault_d = seq_t;
          end
        end
      end else if (st_d != ST_OK && col_d == COL_MAX) begin
        st_d    = ST_OK;
        fault_d = 2'b00;
      end
      // Mode may only follow the fault status between frames
      cc = xg.i_tx_xgmii_ctrl[4*c +: 4];
      cd = xg.i_tx_xgmii_data[32*c +: 32];
      if (!frame_d)
        mode_d = ovr_on;
      has_start = 1'b0;
      for (int l = 0; l < 4; l++) begin
        if (cc[l] && cd[8*l +: 8] == C_START) begin
          has_start = 1'b1;
          frame_d   = 1'b1;
        end
        if (cc[l] && cd[8*l +: 8] == C_TERM)
          frame_d = 1'b0;
      end
      if (mode_d) begin
        if (has_start && cnt_d != '1)
          cnt_d = cnt_d + W_CNT'(1);
        if (fault_q == T_LOCAL) begin
          tx_ctrl_d[4*c +: 4]   = 4'b0001;
          tx_data_d[32*c +: 32] = RF_COL;
        end else begin
          tx_ctrl_d[4*c +: 4]   = 4'hf;
          tx_data_d[32*c +: 32] = IDLE_COL;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      st_q      <= ST_OK;
      seq_q     <= '0;
      type_q    <= 2'b00;
      col_q     <= '0;
      fault_q   <= 2'b00;
      frame_q   <= 1'b0;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      rx_ctrl_q <= '1;
      rx_data_q <= {N_CHANNELS{C_IDLE}};
      tx_ctrl_q <= '1;
      tx_data_q <= {N_CHANNELS{C_IDLE}};
    end else if (i_clk_en) begin
      st_q      <= st_d;
      seq_q     <= seq_d;
      type_q    <= type_d;
      col_q     <= col_d;
      fault_q   <= fault_d;
      frame_q   <= frame_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      rx_ctrl_q <= rx_ctrl_d;
      rx_data_q <= rx_data_d;
      tx_ctrl_q <= tx_ctrl_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign xg.o_rx_xgmii_ctrl = rx_ctrl_q;
  assign xg.o_rx_xgmii_data = rx_data_q;
  assign xg.o_tx_xgmii_ctrl = tx_ctrl_q;
  assign xg.o_tx_xgmii_data = tx_data_q;
  assign o_link_fault       = fault_q;
  assign o_link_up          = (fault_q == 2'b00);
  assign o_suppressed_cnt   = cnt_q;

endmodule

// File: tb/tb_mac_rs_fault.sv
// Bench for mac_rs_fault: random XGMII traffic vs a column-level
// reference model, plus a W_CNT=4 copy for counter saturation.
module tb_mac_rs_fault;
  localparam int N   = 8;
  localparam int FSC = 4;
  localparam int WIN = 128;
  localparam logic [35:0] IDLE_COL = {4'hf, 32'h07070707};
  localparam logic [35:0] RF_COL   = {4'h1, 32'h0200009c};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic cfg = 1'b1;
  logic [1:0]  o_fault, s_fault;
  logic        o_up, s_up;
  logic [15:0] o_cnt;
  logic [3:0]  s_cnt;

  always #5 clk = ~clk;

  mac_rs_fault_if #(.N_CHANNELS(N)) bus ();
  mac_rs_fault_if #(.N_CHANNELS(N)) bus4 ();

  assign bus4.i_rx_xgmii_ctrl = bus.i_rx_xgmii_ctrl;
  assign bus4.i_rx_xgmii_data = bus.i_rx_xgmii_data;
  assign bus4.i_tx_xgmii_ctrl = bus.i_tx_xgmii_ctrl;
  assign bus4.i_tx_xgmii_data = bus.i_tx_xgmii_data;

  mac_rs_fault #(.N_CHANNELS(N), .W_CNT(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_clk_en(en),
    .i_cfg_fault_en(cfg), .xg(bus),
    .o_link_fault(o_fault), .o_link_up(o_up),
    .o_suppressed_cnt(o_cnt)
  );

  mac_rs_fault #(.N_CHANNELS(N), .W_CNT(4)) dut_small (
    .i_clk(clk), .i_reset(rst), .i_clk_en(en),
    .i_cfg_fault_en(cfg), .xg(bus4),
    .o_link_fault(s_fault), .o_link_up(s_up),
    .o_suppressed_cnt(s_cnt)
  );

  int n_run = 0;
  int n_fail = 0;

  logic [35:0] rxq[$];
  logic [35:0] txq[$];
  logic [35:0] drv_rx[2];
  logic [35:0] drv_tx[2];

  // Reference model: link status, frame replacement, expected outputs
  int  m_state, m_seq, m_type, m_gap, m_fault, m_supp;
  bit  m_in_frame, m_repl;
  logic [35:0] e_rx[2];
  logic [35:0] e_tx[2];

  function automatic bit busy();
    return (rxq.size() + txq.size()) != 0;
  endfunction

  function automatic logic [162:0] dut_vec();
    return {bus.o_rx_xgmii_ctrl, bus.o_rx_xgmii_data,
            bus.o_tx_xgmii_ctrl, bus.o_tx_xgmii_data,
            o_fault, o_up, o_cnt};
  endfunction

  function automatic logic [162:0] exp_vec();
    logic [15:0] c;
    c = (m_supp > 65535) ? 16'hffff : 16'(m_supp);
    return {e_rx[1][35:32], e_rx[0][35:32],
            e_rx[1][31:0], e_rx[0][31:0],
            e_tx[1][35:32], e_tx[0][35:32],
            e_tx[1][31:0], e_tx[0][31:0],
            2'(m_fault), (m_fault == 0), c};
  endfunction

  task automatic model_update();
    int t, fprev;
    bit ovr, sof;
    if (rst) begin
      m_state = 0; m_seq = 0; m_type = 0; m_gap = 0;
      m_fault = 0; m_supp = 0;
      m_in_frame = 0; m_repl = 0;
      for (int c = 0; c < 2; c++) begin
        e_rx[c] = IDLE_COL;
        e_tx[c] = IDLE_COL;
      end
    end else if (en) begin
      fprev = m_fault;
      ovr = cfg && (m_fault != 0);
      for (int c = 0; c < 2; c++) begin
        t = 0;
        if (drv_rx[c][35:32] == 4'b0001 &&
            drv_rx[c][23:0] == 24'h00009c &&
            (drv_rx[c][31:24] == 8'h01 || drv_rx[c][31:24] == 8'h02))
          t = int'(drv_rx[c][31:24]);
        e_rx[c] = (t != 0) ? IDLE_COL : drv_rx[c];
        m_gap++;
        if (t != 0) begin
          m_gap = 0;
          if (!(m_state == 2 && t == m_type)) begin
            m_seq = (m_state == 1 && t == m_type) ? m_seq + 1 : 1;
            m_type = t;
            m_state = 1;
            if (m_seq >= FSC) begin
              m_state = 2;
              m_fault = t;
            end
          end
        end else if (m_state != 0 && m_gap > WIN) begin
          m_state = 0;
          m_fault = 0;
        end
        if (!m_in_frame) m_repl = ovr;
        sof = 0;
        for (int l = 0; l < 4; l++) begin
          if (drv_tx[c][32+l] && drv_tx[c][8*l +: 8] == 8'hfb) begin
            sof = 1;
            m_in_frame = 1;
          end
          if (drv_tx[c][32+l] && drv_tx[c][8*l +: 8] == 8'hfd)
            m_in_frame = 0;
        end
        if (m_repl) begin
          if (sof) m_supp++;
          e_tx[c] = (fprev == 1) ? RF_COL : IDLE_COL;
        end else begin
          e_tx[c] = drv_tx[c];
        end
      end
    end
  endtask

  task automatic step();
    for (int c = 0; c < 2; c++) begin
      if (rxq.size() > 0) drv_rx[c] = rxq.pop_front();
      else drv_rx[c] = IDLE_COL;
      if (txq.size() > 0) drv_tx[c] = txq.pop_front();
      else drv_tx[c] = IDLE_COL;
    end
    bus.i_rx_xgmii_ctrl = {drv_rx[1][35:32], drv_rx[0][35:32]};
    bus.i_rx_xgmii_data = {drv_rx[1][31:0], drv_rx[0][31:0]};
    bus.i_tx_xgmii_ctrl = {drv_tx[1][35:32], drv_tx[0][35:32]};
    bus.i_tx_xgmii_data = {drv_tx[1][31:0], drv_tx[0][31:0]};
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic push_frame(input int len);
    logic [35:0] col;
    int k;
    txq.push_back({4'b0001, 24'($urandom()), 8'hfb});
    for (int i = 0; i < len; i++)
      txq.push_back({4'b0000, 32'($urandom())});
    k = $urandom_range(0, 3);
    col = '0;
    for (int l = 0; l < 4; l++) begin
      if (l < k) begin
        col[8*l +: 8] = 8'($urandom());
      end else begin
        col[8*l +: 8] = (l == k) ? 8'hfd : 8'h07;
        col[32+l] = 1'b1;
      end
    end
    txq.push_back(col);
  endtask

  task automatic push_idle_tx(input int n);
    for (int i = 0; i < n; i++) txq.push_back(IDLE_COL);
  endtask

  task automatic push_rx_fill(input int n);
    for (int i = 0; i < n; i++)
      rxq.push_back({4'b0000, 32'($urandom())});
  endtask

  task automatic push_rx_seq(input int t);
    rxq.push_back({4'b0001, 8'(t), 24'h00009c});
  endtask

  task automatic test_reset();
    rst = 1; en = 1; cfg = 1;
    step(); step();
    n_run++;
    if (o_fault !== 2'b00) begin
      n_fail++; $display("FAIL rst_fault: got %b want 00", o_fault);
    end
    n_run++;
    if (o_up !== 1'b1) begin
      n_fail++; $display("FAIL rst_up: got %b want 1", o_up);
    end
    n_run++;
    if (o_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rst_cnt: got %0d want 0", o_cnt);
    end
    n_run++;
    if ({bus.o_tx_xgmii_ctrl, bus.o_tx_xgmii_data} !== {8'hff, 64'h0707070707070707}) begin
      n_fail++; $display("FAIL rst_tx: got %h want all idle", bus.o_tx_xgmii_data);
    end
    n_run++;
    if ({bus.o_rx_xgmii_ctrl, bus.o_rx_xgmii_data} !== {8'hff, 64'h0707070707070707}) begin
      n_fail++; $display("FAIL rst_rx: got %h want all idle", bus.o_rx_xgmii_data);
    end
    rst = 0;
  endtask

  task automatic test_local_fault();
    cfg = 1;
    for (int s = 0; s < 4; s++) begin
      push_rx_seq(1);
      if (s < 3) push_rx_fill(9);
    end
    push_rx_fill(1);
    repeat (3) begin
      push_frame($urandom_range(2, 8));
      push_idle_tx($urandom_range(1, 4));
    end
    for (int i = 0; i < 400 && busy(); i++) begin
      step();
      n_run++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL lf_cycle: dut %h model %h", dut_vec(), exp_vec());
      end
    end
    n_run++;
    if (busy()) begin
      n_fail++; $display("FAIL lf_timeout: %0d left want 0", rxq.size() + txq.size());
    end
    step(); step();
    n_run++;
    if (o_fault !== 2'b01) begin
      n_fail++; $display("FAIL lf_fault: got %b want 01", o_fault);
    end
    n_run++;
    if ({bus.o_tx_xgmii_ctrl, bus.o_tx_xgmii_data} !== {8'h11, 64'h0200009c0200009c}) begin
      n_fail++; $display("FAIL lf_tx_rf: got %h %h want remote-fault set",
                         bus.o_tx_xgmii_ctrl, bus.o_tx_xgmii_data);
    end
  endtask

  task automatic test_window();
    push_rx_fill(140);
    repeat (8) begin
      push_frame($urandom_range(2, 10));
      push_idle_tx($urandom_range(1, 3));
    end
    for (int i = 0; i < 400 && busy(); i++) begin
      step();
      n_run++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL win_cycle: dut %h model %h", dut_vec(), exp_vec());
      end
    end
    n_run++;
    if (o_fault !== 2'b00 || o_up !== 1'b1) begin
      n_fail++; $display("FAIL win_clear: got %b/%b want 00/1", o_fault, o_up);
    end
  endtask

  task automatic test_type_change();
    repeat (3) begin
      push_rx_seq(1);
      push_rx_fill($urandom_range(1, 6));
    end
    push_rx_seq(2);
    push_rx_fill(1);
    for (int i = 0; i < 100 && busy(); i++) begin
      step();
      n_run++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL tc_cycle: dut %h model %h", dut_vec(), exp_vec());
      end
    end
    n_run++;
    if (o_fault !== 2'b00) begin
      n_fail++; $display("FAIL tc_count: got %b want 00", o_fault);
    end
    repeat (3) begin
      push_rx_seq(2);
      push_rx_fill(2);
    end
    for (int i = 0; i < 100 && busy(); i++) step();
    n_run++;
    if (o_fault !== 2'b10) begin
      n_fail++; $display("FAIL tc_remote: got %b want 10", o_fault);
    end
    push_frame(6);
    for (int i = 0; i < 100 && busy(); i++) begin
      step();
      n_run++;
      if ({bus.o_tx_xgmii_ctrl, bus.o_tx_xgmii_data} !== {8'hff, 64'h0707070707070707}) begin
        n_fail++; $display("FAIL tc_tx_idle: got %h %h want idle",
                           bus.o_tx_xgmii_ctrl, bus.o_tx_xgmii_data);
      end
    end
  endtask

  task automatic test_frame_safe();
    bit saw_term, bad_order;
    rst = 1; step(); rst = 0;
    push_frame(20);
    push_idle_tx(2);
    push_frame(3);
    push_idle_tx(2);
    push_rx_fill(4);
    repeat (4) push_rx_seq(1);
    push_rx_fill(10);
    saw_term = 0;
    bad_order = 0;
    for (int i = 0; i < 200 && busy(); i++) begin
      step();
      n_run++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL fs_cycle: dut %h model %h", dut_vec(), exp_vec());
      end
      for (int l = 0; l < N; l++)
        if (bus.o_tx_xgmii_ctrl[l] && bus.o_tx_xgmii_data[8*l +: 8] == 8'hfd)
          saw_term = 1;
      for (int c = 0; c < 2; c++)
        if ({bus.o_tx_xgmii_ctrl[4*c +: 4], bus.o_tx_xgmii_data[32*c +: 32]} == RF_COL &&
            !saw_term)
          bad_order = 1;
    end
    n_run++;
    if (saw_term !== 1'b1 || bad_order !== 1'b0) begin
      n_fail++; $display("FAIL fs_order: term %b early_rf %b want 1 0", saw_term, bad_order);
    end
    n_run++;
    if (o_cnt !== 16'd1) begin
      n_fail++; $display("FAIL fs_cnt: got %0d want 1", o_cnt);
    end
  endtask

  task automatic test_cfg_disable();
    int rf_seen;
    cfg = 0;
    rf_seen = 0;
    repeat (2) begin
      push_rx_seq(1);
      push_rx_fill(50);
    end
    repeat (5) begin
      push_frame($urandom_range(2, 8));
      push_idle_tx($urandom_range(1, 3));
    end
    for (int i = 0; i < 200 && busy(); i++) begin
      step();
      n_run++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL cfg_cycle: dut %h model %h", dut_vec(), exp_vec());
      end
      for (int c = 0; c < 2; c++)
        if ({bus.o_tx_xgmii_ctrl[4*c +: 4], bus.o_tx_xgmii_data[32*c +: 32]} == RF_COL)
          rf_seen++;
    end
    n_run++;
    if (o_fault !== 2'b01 || rf_seen != 0) begin
      n_fail++; $display("FAIL cfg_pass: fault %b rf %0d want 01 0", o_fault, rf_seen);
    end
  endtask

  task automatic test_saturation();
    cfg = 1;
    repeat (8) begin
      push_rx_seq(1);
      push_rx_fill(39);
    end
    repeat (20) begin
      push_frame($urandom_range(1, 3));
      push_idle_tx($urandom_range(1, 2));
    end
    for (int i = 0; i < 400 && busy(); i++) begin
      step();
      n_run++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL sat_cycle: dut %h model %h", dut_vec(), exp_vec());
      end
    end
    n_run++;
    if (o_cnt !== 16'(m_supp)) begin
      n_fail++; $display("FAIL sat_cnt16: got %0d want %0d", o_cnt, m_supp);
    end
    n_run++;
    if (s_cnt !== 4'hf) begin
      n_fail++; $display("FAIL sat_cnt4: got %0d want 15", s_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 6) == 0) push_rx_seq($urandom_range(1, 2));
      else push_rx_fill(1);
    end
    repeat (10) begin
      push_frame($urandom_range(1, 6));
      push_idle_tx($urandom_range(0, 3));
    end
    for (int i = 0; i < 80; i++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) cfg = ~cfg;
      step();
      n_run++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL b2b_cycle: dut %h model %h", dut_vec(), exp_vec());
      end
    end
    en = 1; cfg = 1;
    for (int i = 0; i < 200 && busy(); i++) begin
      step();
      n_run++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL b2b_drain: dut %h model %h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_fault();
    repeat (4) push_rx_seq(1);
    push_frame(30);
    for (int i = 0; i < 4; i++) step();
    n_run++;
    if (o_fault !== 2'b01 || m_fault != 1) begin
      n_fail++; $display("FAIL rmf_pre: got %b want 01", o_fault);
    end
    rst = 1;
    step();
    rst = 0;
    n_run++;
    if ({o_fault, o_up, o_cnt} !== {2'b00, 1'b1, 16'd0}) begin
      n_fail++; $display("FAIL rmf_status: got %b %b %0d want 00 1 0", o_fault, o_up, o_cnt);
    end
    n_run++;
    if ({bus.o_rx_xgmii_ctrl, bus.o_rx_xgmii_data, bus.o_tx_xgmii_ctrl, bus.o_tx_xgmii_data} !==
        {8'hff, 64'h0707070707070707, 8'hff, 64'h0707070707070707}) begin
      n_fail++; $display("FAIL rmf_idle: rx %h tx %h want idle",
                         bus.o_rx_xgmii_data, bus.o_tx_xgmii_data);
    end
    for (int i = 0; i < 100 && busy(); i++) begin
      step();
      n_run++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rmf_cycle: dut %h model %h", dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    drv_rx[0] = IDLE_COL; drv_rx[1] = IDLE_COL;
    drv_tx[0] = IDLE_COL; drv_tx[1] = IDLE_COL;
    bus.i_rx_xgmii_ctrl = '1;
    bus.i_rx_xgmii_data = {N{8'h07}};
    bus.i_tx_xgmii_ctrl = '1;
    bus.i_tx_xgmii_data = {N{8'h07}};
    test_reset();
    test_local_fault();
    test_window();
    test_type_change();
    test_frame_safe();
    test_cfg_disable();
    test_saturation();
    test_back_to_back();
    test_reset_mid_fault();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_rs_fault.md
# mac_rs_fault

Reconciliation-sublayer link-fault block for the 10G MAC, placed between the MAC (TX and RX paths) and the PCS on the XGMII. Detects local/remote fault ordered sets on receive with the IEEE 802.3 clause-46 link-fault state machine. Overrides the transmit XGMII stream accordingly: remote-fault ordered sets on local fault, idles on remote fault. Generalises the plain MAC XGMII pass-through to 4- or 8-lane XGMII, configurable qualification thresholds, and frame-safe override switching.

## Interface
- N_CHANNELS, 8: XGMII lanes per cycle; 4 (one column) or 8 (two columns, lanes 0-3 then 4-7).
- FAULT_SEQ_CNT, 4: same-type fault sequences needed to declare a fault.
- COL_WINDOW, 128: columns without a qualifying sequence before the count or fault clears.
- W_CNT, 16: width of the suppressed-frame counter.
- i_clk in 1: single clock for both XGMII directions.
- i_reset in 1: synchronous, active-high.
- i_clk_en in 1: cycle qualifier; all state and registered outputs hold when low.
- i_cfg_fault_en in 1: 1 enables the TX override; 0 forces pass-through. Detection is unaffected.
- i_rx_xgmii_ctrl in N_CHANNELS: RX control flags from the PCS.
- i_rx_xgmii_data in N_CHANNELS x W_BYTE: RX bytes from the PCS.
- o_rx_xgmii_ctrl / o_rx_xgmii_data out: RX stream to the MAC RX path.
- i_tx_xgmii_ctrl / i_tx_xgmii_data in: TX stream from the MAC TX path.
- o_tx_xgmii_ctrl / o_tx_xgmii_data out: TX stream to the PCS.
- o_link_fault out 2: 00 OK, 01 local fault, 10 remote fault.
- o_link_up out 1: high when o_link_fault == 00.
- o_suppressed_cnt out W_CNT: count of TX frames replaced by the override; saturates at all-ones.

## Operation
- **Character codes.**
  - Control characters: Idle 0x07, Start 0xFB, Terminate 0xFD, Sequence 0x9C.
  - A fault ordered set is a column with ctrl = 0001 and data = {0x9C, 0x00, 0x00, T}.
  - T = 0x01 means local fault; T = 0x02 means remote fault. Any other T is not a fault sequence.
- **Column processing.** Each enabled cycle processes N_CHANNELS/4 columns in lane order. Column 0 updates state before column 1, combinationally within the cycle.
- **States: OK, COUNT, FAULT.**
  - All states: col_cnt increments per processed column.
  - OK + fault seq type T → COUNT, with seq_cnt = 1, last_type = T, col_cnt = 0.
  - COUNT + seq of last_type → seq_cnt++ and col_cnt = 0. When seq_cnt reaches FAULT_SEQ_CNT → FAULT, and o_link_fault = last_type.
  - COUNT + seq of another type → restart with seq_cnt = 1, last_type = new type, col_cnt = 0.
  - COUNT with col_cnt > COL_WINDOW → OK, and o_link_fault = 00.
  - FAULT + seq of last_type → col_cnt = 0.
  - FAULT + seq of another type → COUNT (restart as above). o_link_fault keeps its value until FAULT is re-entered or the window expires.
  - FAULT with col_cnt > COL_WINDOW → OK, and o_link_fault = 00.
- **RX path.** Registered pass-through. Every fault ordered-set column is replaced by 4 Idle characters (ctrl 1111, data 0x07 x4). All other columns are unmodified.
- **TX frame tracking.**
  - in_frame sets on a Start character in the input stream.
  - in_frame clears on a Terminate character.
- **TX override mode.** Override is active when i_cfg_fault_en = 1 and o_link_fault != 00.
  - Local fault: every column carries the remote-fault ordered set {0x9C, 0, 0, 0x02}, ctrl 0001.
  - Remote fault: all lanes carry Idle.
- **TX mode switching.**
  - Modes change only at a column where the input is not mid-frame. A frame in progress at fault assertion passes through complete.
  - An input frame whose Start arrives while override is active is replaced entirely.
  - o_suppressed_cnt increments once per replaced Start.
  - Pass-through resumes at the first non-mid-frame column after override deactivates. A frame already being replaced stays replaced through its Terminate.

## Timing
- Both paths have a registered latency of 1 enabled cycle.
- o_link_fault and o_link_up update in the cycle after the qualifying column is sampled.
- Reset values:
  - o_rx_xgmii_* and o_tx_xgmii_*: all-Idle (ctrl all ones, data 0x07).
  - o_link_fault = 00; o_link_up = 1; o_suppressed_cnt = 0.
  - State OK; in_frame = 0.
- Reset asserted mid-frame or mid-fault returns to the reset values on the next edge. Nothing is flushed.
- col_cnt saturates at COL_WINDOW+1; it does not wrap.
- Two fault sequences in one 8-lane cycle count as two sequences.

## Test plan
- **Local-fault detection.** N_CHANNELS=8. Send 4 local-fault sequences, each 10 columns apart.
  - o_link_fault = 01 one cycle after the 4th.
  - TX carries the remote-fault set {9C,00,00,02} in both columns.
  - RX output shows Idle in place of each sequence.
- **Window expiry.** After fault is declared, send 129 columns with no sequence → o_link_fault returns to 00 and TX returns to pass-through.
- **Type change.** Send 3 local, then 1 remote → state COUNT with seq_cnt = 1. Send 3 more remote → o_link_fault = 10 and TX outputs Idle.
- **Frame-safe switch.** Fault qualifies mid-frame → the current frame's Terminate appears on TX before the override starts. The next MAC frame is suppressed and o_suppressed_cnt = 1.
- **Configuration and saturation.**
  - i_cfg_fault_en = 0 → TX always passes through while o_link_fault still reports.
  - W_CNT=4 with 20 suppressed frames → o_suppressed_cnt = 15.
- **Reset mid-fault.** Assert i_reset with the block in FAULT → next cycle: o_link_fault = 00, all outputs Idle, counter = 0.
